// File: rtl/data_pipe_rr_arbiter_if.sv
// data_pipe_rr_arbiter_if: select/handshake bundle between the arbiter and the NUM:1 interconnect
interface data_pipe_rr_arbiter_if #(
  parameter int NUM   = 8,
  parameter int NSIZE = ($clog2(NUM) < 1) ? 1 : $clog2(NUM),
  parameter int CSIZE = 16
);
  logic [NUM-1:0]   req;
  logic             up_hs;
  logic [NSIZE-1:0] curr_path;
  logic [NSIZE-1:0] sw;
  logic             vld_sw;
  logic [NUM-1:0]   grant_oh;
  logic [CSIZE-1:0] beat_cnt;
  modport master (input req, up_hs, curr_path, output sw, vld_sw, grant_oh, beat_cnt);
  modport slave  (output req, up_hs, curr_path, input sw, vld_sw, grant_oh, beat_cnt);
endinterface

// File: rtl/data_pipe_rr_arbiter.sv
// data_pipe_rr_arbiter: round-robin sw/vld_sw select for the NUM:1 interconnect; `DATA_ARB_FIXED_PRIO_EN selects lowest-index priority
module data_pipe_rr_arbiter #(
  parameter int NUM       = 8,
  parameter int NSIZE     = ($clog2(NUM) < 1) ? 1 : $clog2(NUM),
  parameter int MAX_BEATS = 16,
  parameter int CSIZE     = 16
) (
  input  logic clock,
  input  logic rst_n,
  input  logic clk_en,
  data_pipe_rr_arbiter_if.master bus
);
  localparam logic [1:0] ARB   = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] GRANT = 2'd2;
  localparam logic [1:0] REL   = 2'd3;
  localparam logic [CSIZE-1:0] LAST_BEAT = CSIZE'((MAX_BEATS == 0) ? 0 : MAX_BEATS - 1);
  logic [1:0]       state;
  logic [NSIZE-1:0] last;
  logic [NSIZE-1:0] winner;
  logic             found;
  logic             hit_max;
  logic             req_drop;
`ifndef DATA_ARB_FIXED_PRIO_EN
  localparam int IW = NSIZE + 1;
  logic [NSIZE:0]   idx;
`endif
  assign hit_max  = bus.up_hs && (MAX_BEATS != 0) && (bus.beat_cnt == LAST_BEAT);
  assign req_drop = !bus.req[bus.sw];
  // pick the next requester; scanning backwards lets the first hit in scan order win
  always_comb begin
    winner = '0;
    found  = 1'b0;
`ifdef DATA_ARB_FIXED_PRIO_EN
    for (int i = NUM - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        winner = NSIZE'(i);
        found  = 1'b1;
      end
    end
`else
    idx = '0;
    for (int i = NUM; i >= 1; i--) begin
      idx = {1'b0, last} + IW'(i);
      if (idx >= IW'(NUM)) idx = idx - IW'(NUM);
      if (bus.req[idx[NSIZE-1:0]]) begin
        winner = idx[NSIZE-1:0];
        found  = 1'b1;
      end
    end
`endif
  end
  // grant FSM with beat counter; select outputs are registered and drop on entry to REL
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state        <= ARB;
      bus.sw       <= '0;
      bus.vld_sw   <= 1'b0;
      bus.grant_oh <= '0;
      bus.beat_cnt <= '0;
      last         <= NSIZE'(NUM - 1);
    end else if (clk_en) begin
      case (state)
        ARB: begin
          if (found) begin
            bus.sw       <= winner;
            bus.vld_sw   <= 1'b1;
            bus.grant_oh <= NUM'(1) << winner;
            bus.beat_cnt <= '0;
            state        <= WAIT;
          end
        end
        WAIT: begin
          if (bus.curr_path == bus.sw) state <= GRANT;
          else if (req_drop) begin
            bus.vld_sw   <= 1'b0;
            bus.grant_oh <= '0;
            state        <= REL;
          end
        end
        GRANT: begin
          if (bus.up_hs && bus.beat_cnt != '1) bus.beat_cnt <= bus.beat_cnt + CSIZE'(1);
          if (hit_max || (req_drop && !bus.up_hs)) begin
            bus.vld_sw   <= 1'b0;
            bus.grant_oh <= '0;
            state        <= REL;
          end
        end
        default: begin
`ifndef DATA_ARB_FIXED_PRIO_EN
          last <= bus.sw;
`endif
          bus.beat_cnt <= '0;
          state        <= ARB;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_data_pipe_rr_arbiter.sv
// tb_data_pipe_rr_arbiter: scoreboard bench for the select arbiter (grant order, beats, gaps, reset, clock enable)
`timescale 1ns/1ps
module tb_data_pipe_rr_arbiter;
  localparam int NUM   = 4;
  localparam int NSIZE = 2;
  localparam int CSIZE = 16;
  typedef struct { int sw; int beats; int gap; } grant_t;
  logic clock = 1'b0;
  logic rst_n = 1'b0;
  logic clk_en = 1'b1;
  logic hs_en = 1'b1;
  logic [NUM-1:0] req0 = '0;
  logic [NUM-1:0] req1 = '0;
  int errors = 0;
  int checks = 0;
  int done = 0;
  int gap = 0;
  logic prev_vld = 1'b0;
  logic have_cur = 1'b0;
  grant_t cur;
  grant_t exp_q[$];
  always #5 clock = ~clock;
  data_pipe_rr_arbiter_if #(.NUM(NUM), .NSIZE(NSIZE), .CSIZE(CSIZE)) b0 ();
  data_pipe_rr_arbiter_if #(.NUM(NUM), .NSIZE(NSIZE), .CSIZE(CSIZE)) b1 ();
  assign b0.req       = req0;
  assign b0.curr_path = b0.sw;
  assign b0.up_hs     = hs_en && b0.vld_sw && b0.req[b0.sw];
  assign b1.req       = req1;
  assign b1.curr_path = b1.sw;
  assign b1.up_hs     = hs_en && b1.vld_sw && b1.req[b1.sw];
  data_pipe_rr_arbiter #(.NUM(NUM), .NSIZE(NSIZE), .MAX_BEATS(4), .CSIZE(CSIZE)) u0 (
    .clock(clock), .rst_n(rst_n), .clk_en(clk_en), .bus(b0));
  data_pipe_rr_arbiter #(.NUM(NUM), .NSIZE(NSIZE), .MAX_BEATS(0), .CSIZE(CSIZE)) u1 (
    .clock(clock), .rst_n(rst_n), .clk_en(clk_en), .bus(b1));

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  task automatic push(input int s, input int b, input int g);
    grant_t t;
    t.sw = s;
    t.beats = b;
    t.gap = g;
    exp_q.push_back(t);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    clk_en = 1'b1;
    req0 = '0;
    req1 = '0;
    repeat (2) @(posedge clock);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_done(input int target, input bit toggle);
    int c = 0;
    while (done < target && c < 400) begin
      @(posedge clock);
      #2;
      if (toggle) clk_en = ~clk_en;
      c++;
    end
    if (done < target) fail("timeout waiting for grant release");
  endtask

  task automatic wait_cnt(input int n);
    int c = 0;
    while (b0.beat_cnt != CSIZE'(n) && c < 100) begin
      @(posedge clock);
      #1;
      c++;
    end
    if (b0.beat_cnt != CSIZE'(n)) fail("timeout waiting for beat_cnt");
  endtask

  // monitor: pop an expected grant on every vld_sw rise, check its beat count on the fall
  always @(negedge clock) begin
    check("grant_oh", b0.grant_oh, b0.vld_sw ? (1 << b0.sw) : 0);
    if (b0.vld_sw && !prev_vld) begin
      if (exp_q.size() == 0) fail("unexpected grant");
      else begin
        cur = exp_q.pop_front();
        have_cur = 1'b1;
        check("grant sw", b0.sw, cur.sw);
        if (cur.gap >= 0) check("grant gap", gap, cur.gap);
      end
    end else if (b0.vld_sw && have_cur) check("sw stable", b0.sw, cur.sw);
    if (!b0.vld_sw && prev_vld) begin
      if (have_cur) check("grant beats", b0.beat_cnt, cur.beats);
      have_cur = 1'b0;
      done++;
    end
    gap = b0.vld_sw ? 0 : gap + 1;
    prev_vld = b0.vld_sw;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int drops;
    reset_dut();
    @(negedge clock);
    check("reset vld_sw", b0.vld_sw, 0);
    check("reset sw", b0.sw, 0);
    check("reset grant_oh", b0.grant_oh, 0);
    check("reset beat_cnt", b0.beat_cnt, 0);
    check("reset vld_sw u1", b1.vld_sw, 0);
    // T1: two requesters, 4-beat grants
    t = done + 4;
`ifdef DATA_ARB_FIXED_PRIO_EN
    push(0, 4, -1); push(0, 4, 2); push(0, 4, 2); push(0, 4, 2);
`else
    push(0, 4, -1); push(2, 4, 2); push(0, 4, 2); push(2, 4, 2);
`endif
    @(posedge clock);
    #1 req0 = 4'b0101;
    @(negedge clock);
    check("latency before edge", b0.vld_sw, 0);
    @(negedge clock);
    check("latency one cycle", b0.vld_sw, 1);
    wait_done(t, 1'b0);
    req0 = '0;
    repeat (3) @(posedge clock);
    // T2: all requesting, full rotation
    reset_dut();
    t = done + 5;
`ifdef DATA_ARB_FIXED_PRIO_EN
    push(0, 4, -1); push(0, 4, 2); push(0, 4, 2); push(0, 4, 2); push(0, 4, 2);
`else
    push(0, 4, -1); push(1, 4, 2); push(2, 4, 2); push(3, 4, 2); push(0, 4, 2);
`endif
    req0 = 4'b1111;
    wait_done(t, 1'b0);
    req0 = '0;
    repeat (3) @(posedge clock);
    // T3: requester drops after 3 beats, next grant to port 2
    reset_dut();
    t = done + 2;
    push(1, 3, -1); push(2, 4, 2);
    req0 = 4'b0010;
    wait_cnt(3);
    req0 = 4'b0100;
    wait_done(t, 1'b0);
    req0 = '0;
    repeat (3) @(posedge clock);
    // T4: clock enable toggling every cycle, only enabled beats count
    reset_dut();
    t = done + 1;
    push(1, 4, -1);
    req0 = 4'b0010;
    wait_done(t, 1'b1);
    req0 = '0;
    clk_en = 1'b1;
    repeat (3) @(posedge clock);
    // T5: reset at beat 2 of a grant to port 3, then single-requester re-grant
    reset_dut();
    t = done + 3;
    push(3, 0, -1); push(3, 4, -1); push(3, 4, 2);
    req0 = 4'b1000;
    wait_cnt(2);
    rst_n = 1'b0;
    @(posedge clock);
    #1 rst_n = 1'b1;
    @(negedge clock);
    check("mid-grant reset vld_sw", b0.vld_sw, 0);
    check("mid-grant reset sw", b0.sw, 0);
    check("mid-grant reset beat_cnt", b0.beat_cnt, 0);
    @(negedge clock);
    check("regrant after reset vld_sw", b0.vld_sw, 1);
    check("regrant after reset sw", b0.sw, 3);
    wait_done(t, 1'b0);
    req0 = '0;
    repeat (3) @(posedge clock);
    // T6: MAX_BEATS=0 holds the grant until the requester drops
    reset_dut();
    req1 = 4'b0010;
    for (int c = 0; c < 20 && !b1.vld_sw; c++) @(negedge clock);
    check("t6 grant vld_sw", b1.vld_sw, 1);
    check("t6 grant sw", b1.sw, 1);
    check("t6 grant_oh", b1.grant_oh, 2);
    drops = 0;
    for (int i = 0; i < 101; i++) begin
      @(negedge clock);
      if (!b1.vld_sw) drops++;
    end
    check("t6 vld_sw drops", drops, 0);
    check("t6 beat_cnt", b1.beat_cnt, 100);
    req1 = '0;
    @(negedge clock);
    check("t6 release vld_sw", b1.vld_sw, 0);
    check("t6 release beat_cnt", b1.beat_cnt, 100);
    repeat (3) @(posedge clock);
    check("scoreboard drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
